// File: rtl/cde_ctrl.sv
// rtl/cde_ctrl.sv - sequencing FSM for the credential datapath (CAM, flash staging, AES)
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_op    command request; 01=STORE, 10=RETRIEVE, 00/11 illegal
//   cmd_ready           idle and accepting a command
//   match               CAM hit for the current account
//   ready_encryption    AES encrypt output valid
//   flash_or_acc_sel, flash_or_acc_reg, flash_acc_reg, flash_pass_reg   staging selects/enables
//   pass_enc_reg, new_old_pass_sel, plain_reg                           cipher-path enables/select
//   local_master_reg, local_master_sel, out_reg                         key-path/output enables/select
//   write_en, write_add  CAM write strobe and write slot (also the flash slot)
//   boot_lood            1 = flash address comes from CAM match_addr
//   flash_rd, flash_we   single-cycle flash strobes
//   done, err            completion pulse and status (err holds until the next done)
//   used                 occupied slot count
module cde_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int FLASH_RD_LAT = 2,
    parameter int ENC_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_ready,
    input  logic                  match,
    input  logic                  ready_encryption,
    output logic                  flash_or_acc_sel,
    output logic                  flash_or_acc_reg,
    output logic                  flash_acc_reg,
    output logic                  flash_pass_reg,
    output logic                  pass_enc_reg,
    output logic                  new_old_pass_sel,
    output logic                  plain_reg,
    output logic                  local_master_reg,
    output logic                  local_master_sel,
    output logic                  out_reg,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_add,
    output logic                  boot_lood,
    output logic                  flash_rd,
    output logic                  flash_we,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADDR_WIDTH:0]   used
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(ENC_TIMEOUT + FLASH_RD_LAT + 1);

    localparam logic [CW-1:0]       ENC_LAST = CW'(ENC_TIMEOUT - 1);
    localparam logic [CW-1:0]       RD_LAST  = CW'(FLASH_RD_LAT - 1);
    localparam logic [ADDR_WIDTH:0] FULL     = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_RETR  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_LOAD, S_ACC, S_ENC, S_COMMIT,
        S_RD, S_PEN, S_DEC, S_LOAD2, S_ENC2, S_DONE
    } state_t;

    state_t          state, state_d;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [1:0]      err_d;

    // State register plus the few data registers that ride along with it.
    // cnt counts cycles spent in the current state; it restarts on every
    // transition, so it measures both the flash read wait and the encrypt wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= 2'b00;
            cnt   <= '0;
            used  <= '0;
            err   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= (state_d == state) ? cnt + CW'(1) : '0;
            if (state == S_IDLE && cmd_valid)
                op_q <= cmd_op;
            if (state_d == S_DONE)
                err <= err_d;
            if (state == S_COMMIT && used != FULL)
                used <= used + (ADDR_WIDTH + 1)'(1);
        end
    end

    // Next-state and status to report when the command finishes.
    always_comb begin
        state_d = state;
        err_d   = 2'd0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_STORE || cmd_op == OP_RETR) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 2'd3;
                    end
                end
            end
            S_CHK: begin
                if (op_q == OP_STORE) begin
                    if (match) begin
                        state_d = S_DONE;
                        err_d   = 2'd1;
                    end else if (used == FULL) begin
                        state_d = S_DONE;
                        err_d   = 2'd2;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    if (!match) begin
                        state_d = S_DONE;
                        err_d   = 2'd1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_LOAD:   state_d = S_ACC;
            S_ACC:    state_d = S_ENC;
            S_ENC: begin
                if (ready_encryption) begin
                    state_d = S_COMMIT;
                end else if (cnt == ENC_LAST) begin
                    state_d = S_DONE;
                    err_d   = 2'd3;
                end
            end
            S_COMMIT: state_d = S_DONE;
            S_RD:     if (cnt == RD_LAST) state_d = S_PEN;
            S_PEN:    state_d = S_DEC;
            S_DEC:    state_d = S_LOAD2;
            S_LOAD2:  state_d = S_ENC2;
            S_ENC2: begin
                if (ready_encryption) begin
                    state_d = S_DONE;
                end else if (cnt == ENC_LAST) begin
                    state_d = S_DONE;
                    err_d   = 2'd3;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath controls. Selects stay up through the cycle after their
    // enable so the downstream register sees a settled mux. flash_pass_reg
    // and out_reg fire in the same cycle ready_encryption is seen, so the
    // cipher result is captured before COMMIT/DONE.
    always_comb begin
        cmd_ready        = rst && (state == S_IDLE);
        flash_or_acc_sel = 1'b0;
        flash_or_acc_reg = 1'b0;
        flash_acc_reg    = 1'b0;
        flash_pass_reg   = 1'b0;
        pass_enc_reg     = 1'b0;
        new_old_pass_sel = 1'b0;
        plain_reg        = 1'b0;
        local_master_reg = 1'b0;
        local_master_sel = 1'b0;
        out_reg          = 1'b0;
        write_en         = 1'b0;
        write_add        = '0;
        boot_lood        = 1'b0;
        flash_rd         = 1'b0;
        flash_we         = 1'b0;
        done             = 1'b0;
        unique case (state)
            S_LOAD: begin
                flash_or_acc_sel = 1'b1;
                flash_or_acc_reg = 1'b1;
                plain_reg        = 1'b1;
                local_master_reg = 1'b1;
            end
            S_ACC: begin
                flash_or_acc_sel = 1'b1;
                flash_acc_reg    = 1'b1;
            end
            S_ENC:    flash_pass_reg = ready_encryption;
            S_COMMIT: begin
                flash_we  = 1'b1;
                write_en  = 1'b1;
                write_add = used[ADDR_WIDTH-1:0];
            end
            S_RD: begin
                boot_lood = 1'b1;
                flash_rd  = (cnt == '0);
            end
            S_PEN: begin
                boot_lood    = 1'b1;
                pass_enc_reg = 1'b1;
            end
            S_LOAD2: begin
                new_old_pass_sel = 1'b1;
                plain_reg        = 1'b1;
                local_master_sel = 1'b1;
                local_master_reg = 1'b1;
            end
            S_ENC2: begin
                new_old_pass_sel = 1'b1;
                local_master_sel = 1'b1;
                out_reg          = ready_encryption;
            end
            S_DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cde_ctrl.sv
// tb/tb_cde_ctrl.sv - self-checking bench for cde_ctrl against a per-cycle command timeline model
module tb_cde_ctrl;

    localparam int AW     = 4;
    localparam int RD_LAT = 2;
    localparam int TMO    = 64;
    localparam int DEPTH  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic          match = 1'b0;
    logic          ready_encryption = 1'b0;
    logic          cmd_ready;
    logic          flash_or_acc_sel, flash_or_acc_reg, flash_acc_reg, flash_pass_reg;
    logic          pass_enc_reg, new_old_pass_sel, plain_reg;
    logic          local_master_reg, local_master_sel, out_reg;
    logic          write_en;
    logic [AW-1:0] write_add;
    logic          boot_lood, flash_rd, flash_we, done;
    logic [1:0]    err;
    logic [AW:0]   used;

    cde_ctrl #(.ADDR_WIDTH(AW), .FLASH_RD_LAT(RD_LAT), .ENC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .match(match), .ready_encryption(ready_encryption),
        .flash_or_acc_sel(flash_or_acc_sel), .flash_or_acc_reg(flash_or_acc_reg),
        .flash_acc_reg(flash_acc_reg), .flash_pass_reg(flash_pass_reg),
        .pass_enc_reg(pass_enc_reg), .new_old_pass_sel(new_old_pass_sel), .plain_reg(plain_reg),
        .local_master_reg(local_master_reg), .local_master_sel(local_master_sel), .out_reg(out_reg),
        .write_en(write_en), .write_add(write_add), .boot_lood(boot_lood),
        .flash_rd(flash_rd), .flash_we(flash_we), .done(done), .err(err), .used(used)
    );

    always #5 clk = ~clk;

    // Bit positions of the packed output vector.
    localparam int P_USED = 0, P_ERR = 5, P_DONE = 7, P_FWE = 8, P_FRD = 9, P_BOOT = 10;
    localparam int P_WADD = 11, P_WEN = 15, P_OUTR = 16, P_LMSEL = 17, P_LMREG = 18;
    localparam int P_PLAIN = 19, P_NOPSEL = 20, P_PENC = 21, P_FPASS = 22, P_FACC = 23;
    localparam int P_FOAREG = 24, P_FOASEL = 25, P_RDY = 26;

    // Selects, boot_lood and write_add only matter in specific cycles.
    localparam logic [26:0] CARE_DEF = ~((27'd1 << P_FOASEL) | (27'd1 << P_NOPSEL) |
                                         (27'd1 << P_LMSEL) | (27'd1 << P_BOOT) |
                                         (27'hF << P_WADD));
    localparam logic [26:0] CARE_ALL = '1;

    typedef struct {
        logic [26:0] val;
        logic [26:0] care;
        string       name;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          done_cyc = -1;
    int          wen_cnt  = 0;
    int          m_used   = 0;
    logic [1:0]  m_err    = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [26:0] a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {cmd_ready, flash_or_acc_sel, flash_or_acc_reg, flash_acc_reg, flash_pass_reg,
                 pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg, local_master_sel,
                 out_reg, write_en, write_add, boot_lood, flash_rd, flash_we, done, err, used};
            n_checks++;
            if (((a ^ e.val) & e.care) !== 27'd0)
                $display("FAIL %s cyc=%0d actual=%h required=%h care=%h", e.name, cyc, a, e.val, e.care);
            else
                n_pass++;
            if (done === 1'b1) done_cyc = cyc;
            if (write_en === 1'b1) wen_cnt++;
        end
    end

    task automatic check_int(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        else n_pass++;
    endtask

    function automatic logic [26:0] base();
        logic [26:0] v;
        v = '0;
        v[P_USED +: 5] = m_used[4:0];
        v[P_ERR +: 2]  = m_err;
        return v;
    endfunction

    task automatic step(input string nm, input logic [26:0] v, input logic [26:0] c);
        exp_t e;
        e.val  = v;
        e.care = c;
        e.name = nm;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [26:0] v;
        for (int i = 0; i < n; i++) begin
            v = base();
            v[P_RDY] = 1'b1;
            step("idle", v, CARE_DEF);
        end
    endtask

    task automatic run_illegal(input logic [1:0] op, output int acc);
        logic [26:0] v;
        cmd_valid = 1'b1; cmd_op = op;
        v = base(); v[P_RDY] = 1'b1; acc = cyc;
        step("il_accept", v, CARE_DEF);
        cmd_valid = 1'b0;
        m_err = 2'd3;
        v = base(); v[P_DONE] = 1'b1;
        step("il_done", v, CARE_DEF);
    endtask

    // w = encrypt-wait cycles (ready in the w-th ENC cycle), 0 = never ready.
    // abort_k >= 0 pulses rst low in that ENC cycle.
    task automatic run_store(input logic m, input int w, input int abort_k, output int acc);
        logic [26:0] v, c;
        int n;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        v = base(); v[P_RDY] = 1'b1; acc = cyc;
        step("st_accept", v, CARE_DEF);
        cmd_valid = 1'b0; match = m;
        step("st_chk", base(), CARE_DEF);
        match = 1'b0;
        if (m || m_used == DEPTH) begin
            m_err = m ? 2'd1 : 2'd2;
            v = base(); v[P_DONE] = 1'b1;
            step("st_done_rej", v, CARE_DEF);
            return;
        end
        v = base(); v[P_FOASEL] = 1'b1; v[P_FOAREG] = 1'b1; v[P_PLAIN] = 1'b1; v[P_LMREG] = 1'b1;
        c = CARE_DEF; c[P_FOASEL] = 1'b1; c[P_NOPSEL] = 1'b1; c[P_LMSEL] = 1'b1;
        step("st_load", v, c);
        v = base(); v[P_FACC] = 1'b1; v[P_FOASEL] = 1'b1;
        step("st_acc", v, c);
        n = (w == 0) ? TMO : w;
        for (int k = 0; k < n; k++) begin
            ready_encryption = (w != 0 && k == n - 1);
            v = base(); v[P_FPASS] = ready_encryption;
            if (k == abort_k) begin
                rst = 1'b0;
                step("st_enc_rst", v, CARE_DEF);
                rst = 1'b1;
                m_err = 2'd0;
                v = base(); v[P_RDY] = 1'b1;
                step("post_rst", v, CARE_ALL);
                return;
            end
            step("st_enc", v, CARE_DEF);
        end
        ready_encryption = 1'b0;
        if (w == 0) begin
            m_err = 2'd3;
        end else begin
            v = base(); v[P_FWE] = 1'b1; v[P_WEN] = 1'b1; v[P_WADD +: 4] = m_used[3:0];
            c = CARE_DEF; c[P_WADD +: 4] = 4'hF; c[P_BOOT] = 1'b1;
            step("st_commit", v, c);
            m_used++;
            m_err = 2'd0;
        end
        v = base(); v[P_DONE] = 1'b1;
        step("st_done", v, CARE_DEF);
    endtask

    task automatic run_retrieve(input logic m, input int w, input logic busy_valid, output int acc);
        logic [26:0] v, c;
        int n;
        cmd_valid = 1'b1; cmd_op = 2'b10;
        v = base(); v[P_RDY] = 1'b1; acc = cyc;
        step("rt_accept", v, CARE_DEF);
        cmd_valid = busy_valid; cmd_op = 2'b01; match = m;
        step("rt_chk", base(), CARE_DEF);
        match = 1'b0;
        if (!m) begin
            cmd_valid = 1'b0;
            m_err = 2'd1;
            v = base(); v[P_DONE] = 1'b1;
            step("rt_done_miss", v, CARE_DEF);
            return;
        end
        for (int j = 0; j < RD_LAT; j++) begin
            v = base(); v[P_BOOT] = 1'b1; v[P_FRD] = (j == 0);
            c = CARE_DEF; c[P_BOOT] = 1'b1;
            step("rt_rd", v, c);
        end
        v = base(); v[P_PENC] = 1'b1; v[P_BOOT] = 1'b1;
        c = CARE_DEF; c[P_BOOT] = 1'b1;
        step("rt_pen", v, c);
        step("rt_dec", base(), CARE_DEF);
        v = base(); v[P_NOPSEL] = 1'b1; v[P_PLAIN] = 1'b1; v[P_LMSEL] = 1'b1; v[P_LMREG] = 1'b1;
        c = CARE_DEF; c[P_NOPSEL] = 1'b1; c[P_LMSEL] = 1'b1;
        step("rt_load2", v, c);
        n = (w == 0) ? TMO : w;
        for (int k = 0; k < n; k++) begin
            ready_encryption = (w != 0 && k == n - 1);
            v = base(); v[P_OUTR] = ready_encryption;
            c = CARE_DEF;
            if (k == 0) begin
                v[P_NOPSEL] = 1'b1; v[P_LMSEL] = 1'b1;
                c[P_NOPSEL] = 1'b1; c[P_LMSEL] = 1'b1;
            end
            step("rt_enc2", v, c);
        end
        ready_encryption = 1'b0;
        cmd_valid = 1'b0;
        m_err = (w == 0) ? 2'd3 : 2'd0;
        v = base(); v[P_DONE] = 1'b1;
        step("rt_done", v, CARE_DEF);
    endtask

    initial begin
        int acc;
        int prev_done;
        logic [26:0] v;

        @(posedge clk);
        #1;
        step("rst_hold", base(), CARE_ALL);
        step("rst_hold", base(), CARE_ALL);
        rst = 1'b1;
        idle(2);

        run_illegal(2'b11, acc);
        check_int("illegal_latency", done_cyc - acc, 1);
        idle(1);
        run_illegal(2'b00, acc);
        check_int("illegal00_err", int'(err), 3);

        run_store(1'b1, 3, -1, acc);
        check_int("dup_latency", done_cyc - acc, 2);
        check_int("dup_err", int'(err), 1);

        prev_done = done_cyc;
        run_store(1'b0, 5, 1, acc);
        check_int("rst_no_done", done_cyc, prev_done);
        check_int("rst_used", int'(used), 0);
        idle(1);

        run_store(1'b0, 3, -1, acc);
        check_int("store_latency", done_cyc - acc, 8);
        check_int("store_used", int'(used), 1);
        check_int("store_err", int'(err), 0);

        run_retrieve(1'b1, 4, 1'b1, acc);
        check_int("retr_latency", done_cyc - acc, 11);
        idle(1);
        run_retrieve(1'b0, 2, 1'b0, acc);
        check_int("retr_miss_latency", done_cyc - acc, 2);
        run_retrieve(1'b1, 0, 1'b0, acc);
        check_int("retr_tmo_latency", done_cyc - acc, 71);
        check_int("retr_tmo_err", int'(err), 3);

        run_store(1'b0, 0, -1, acc);
        check_int("store_tmo_latency", done_cyc - acc, 68);
        check_int("store_tmo_used", int'(used), 1);

        for (int i = 1; i < DEPTH; i++) run_store(1'b0, 1 + (i % 3), -1, acc);
        check_int("fill_used", int'(used), 16);
        check_int("fill_writes", wen_cnt, 16);

        run_store(1'b0, 2, -1, acc);
        check_int("full_latency", done_cyc - acc, 2);
        check_int("full_err", int'(err), 2);
        check_int("full_used", int'(used), 16);

        v = base(); v[P_RDY] = 1'b1;
        step("final_idle", v, CARE_DEF);
        idle(2);
        check_int("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
